// File: rtl/pmp_pkg.sv
// Shared types for the phase-matching scheduler: input FSM states, per-lane
// phase-FIFO and disparity-FIFO words, and their default field widths.
package pmp_pkg;

  localparam int PMP_DATA_WIDTH = 16;
  localparam int PMP_POS_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CACHE = 2'd1,
    S_PHASE = 2'd2
  } state_e;

  typedef struct packed {
    logic                      last;
    logic [PMP_POS_WIDTH-1:0]  pos;
    logic [PMP_DATA_WIDTH-1:0] pix;
  } phase_word_t;

  typedef struct packed {
    logic                      last;
    logic [PMP_DATA_WIDTH-1:0] dis;
  } dis_word_t;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry skid FIFO with registered outputs: 1 cycle push-to-valid,
// accepts a push whenever the second slot is free, full rate while out_rdy=1.
module axis_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] d0, d1;
  logic             v0, v1;
  logic             push, pop;

  assign in_rdy  = ~v1;
  assign push    = in_vld & ~v1;
  assign pop     = v0 & out_rdy;
  assign out_vld = v0;
  assign out_dat = d0;

  // push is blocked while v1 is set, so push+pop always sees exactly one entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!v0) begin
            d0 <= in_dat;
            v0 <= 1'b1;
          end else begin
            d1 <= in_dat;
            v1 <= 1'b1;
          end
        end
        2'b01: begin
          d0 <= d1;
          v0 <= v1;
          v1 <= 1'b0;
        end
        2'b11: d0 <= in_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/phase_sched_ctrl.sv
// Splits row pairs into cache stream and position-tagged phase FIFOs, and
// gathers lane-aligned disparity words into a registered output stream.
module phase_sched_ctrl
  import pmp_pkg::*;
#(
  parameter  int BEAT_SIZE     = 8,
  parameter  int DATA_WIDTH    = PMP_DATA_WIDTH,
  parameter  int POS_WIDTH     = PMP_POS_WIDTH,
  parameter  int MAX_ROW_BEATS = 1024,
  localparam int CW            = $clog2(MAX_ROW_BEATS + 1),
  localparam int PW            = 1 + POS_WIDTH + DATA_WIDTH,
  localparam int DW1           = DATA_WIDTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CW-1:0]                   cfg_row_beats,
  input  logic                            cfg_swap,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_cache_axis_tdata,
  output logic                            m_cache_axis_tvalid,
  input  logic                            m_cache_axis_tready,
  output logic                            m_cache_axis_tlast,
  output logic                            phase_buf_wr_en,
  output logic [BEAT_SIZE*PW-1:0]         phase_buf_din,
  input  logic [BEAT_SIZE-1:0]            phase_buf_pfull,
  output logic [BEAT_SIZE-1:0]            dis_buf_rd_en,
  input  logic [BEAT_SIZE-1:0]            dis_buf_empty,
  input  logic [BEAT_SIZE*DW1-1:0]        dis_buf_dout,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [15:0]                     row_pair_cnt,
  output logic                            err_len,
  output logic                            err_lane
);

  state_e                          state, first_st;
  logic                            swap_r;
  logic [CW-1:0]                   len_r, beat_cnt;
  logic                            accept, at_last;
  logic [POS_WIDTH-1:0]            pos_base;
  logic [BEAT_SIZE*DATA_WIDTH-1:0] rd_dat;
  logic [BEAT_SIZE-1:0]            lane_last;
  logic                            skid_rdy, all_rdy, lane_mis;
  logic [BEAT_SIZE*DATA_WIDTH:0]   skid_out;

  assign first_st = swap_r ? S_PHASE : S_CACHE;
  assign at_last  = (beat_cnt == len_r - CW'(1));
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign pos_base = POS_WIDTH'(beat_cnt) * POS_WIDTH'(BEAT_SIZE);

  always_comb begin
    s_axis_tready       = 1'b0;
    m_cache_axis_tvalid = 1'b0;
    case (state)
      S_CACHE: begin
        s_axis_tready       = m_cache_axis_tready;
        m_cache_axis_tvalid = s_axis_tvalid;
      end
      S_PHASE: s_axis_tready = ~|phase_buf_pfull;
      default: ;
    endcase
  end

  assign m_cache_axis_tdata = s_axis_tdata;
  assign m_cache_axis_tlast = at_last & (state == S_CACHE);
  assign phase_buf_wr_en    = accept & (state == S_PHASE);

  // Row boundaries come from the beat counter; tlast only flags a length error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      swap_r       <= 1'b0;
      len_r        <= '0;
      beat_cnt     <= '0;
      row_pair_cnt <= '0;
      err_len      <= 1'b0;
    end else if (state == S_IDLE) begin
      swap_r <= cfg_swap;
      len_r  <= cfg_row_beats;
      state  <= cfg_swap ? S_PHASE : S_CACHE;
    end else if (accept) begin
      if (s_axis_tlast != at_last) err_len <= 1'b1;
      if (at_last) begin
        beat_cnt <= '0;
        len_r    <= cfg_row_beats;
        if (state != first_st) begin
          state        <= S_IDLE;
          row_pair_cnt <= row_pair_cnt + 16'd1;
        end else begin
          state <= swap_r ? S_CACHE : S_PHASE;
        end
      end else begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < BEAT_SIZE; i++) begin : g_lane
    phase_word_t pw;
    dis_word_t   dw;
    assign pw.last = at_last;
    assign pw.pos  = pos_base + POS_WIDTH'(i);
    assign pw.pix  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign phase_buf_din[i*PW +: PW] = pw;
    assign dw = dis_buf_dout[i*DW1 +: DW1];
    assign rd_dat[i*DATA_WIDTH +: DATA_WIDTH] = dw.dis;
    assign lane_last[i] = dw.last;
  end

  assign all_rdy       = ~rst & ~|dis_buf_empty & skid_rdy;
  assign dis_buf_rd_en = {BEAT_SIZE{all_rdy}};
  assign lane_mis      = |(lane_last ^ {BEAT_SIZE{lane_last[0]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_lane <= 1'b0;
    else if (all_rdy && lane_mis) err_lane <= 1'b1;
  end

  axis_skid2 #(.WIDTH(BEAT_SIZE*DATA_WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (all_rdy),
    .in_dat  ({lane_last[0], rd_dat}),
    .in_rdy  (skid_rdy),
    .out_vld (m_axis_tvalid),
    .out_dat (skid_out),
    .out_rdy (m_axis_tready)
  );

  assign m_axis_tlast = skid_out[BEAT_SIZE*DATA_WIDTH];
  assign m_axis_tdata = skid_out[BEAT_SIZE*DATA_WIDTH-1:0];

endmodule

// File: tb/tb_phase_sched_ctrl.sv
// Directed bench for phase_sched_ctrl with scoreboards on the cache, phase and
// disparity streams plus a behavioural model of the per-lane FWFT FIFOs.
module tb_phase_sched_ctrl;

  localparam int BS  = 8;
  localparam int DW  = 16;
  localparam int CW  = 11;
  localparam int PWD = 33;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CW-1:0]     cfg_row_beats = 11'd160;
  logic              cfg_swap = 1'b0;
  logic [BS*DW-1:0]  s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [BS*DW-1:0]  m_cache_axis_tdata;
  logic              m_cache_axis_tvalid;
  logic              m_cache_axis_tready = 1'b0;
  logic              m_cache_axis_tlast;
  logic              phase_buf_wr_en;
  logic [BS*PWD-1:0] phase_buf_din;
  logic [BS-1:0]     phase_buf_pfull = '0;
  logic [BS-1:0]     dis_buf_rd_en;
  logic [BS-1:0]     dis_buf_empty;
  logic [BS*17-1:0]  dis_buf_dout;
  logic [BS*DW-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [15:0]       row_pair_cnt;
  logic              err_len;
  logic              err_lane;

  int checks = 0;
  int errors = 0;

  logic [BS*DW:0]    cache_q[$];
  logic [BS*PWD-1:0] phase_q[$];
  logic [BS*DW:0]    out_q[$];

  logic [DW:0] lmem [BS][64];
  int          wp [BS];
  int          rp [BS];

  phase_sched_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_row_beats       (cfg_row_beats),
    .cfg_swap            (cfg_swap),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .m_cache_axis_tdata  (m_cache_axis_tdata),
    .m_cache_axis_tvalid (m_cache_axis_tvalid),
    .m_cache_axis_tready (m_cache_axis_tready),
    .m_cache_axis_tlast  (m_cache_axis_tlast),
    .phase_buf_wr_en     (phase_buf_wr_en),
    .phase_buf_din       (phase_buf_din),
    .phase_buf_pfull     (phase_buf_pfull),
    .dis_buf_rd_en       (dis_buf_rd_en),
    .dis_buf_empty       (dis_buf_empty),
    .dis_buf_dout        (dis_buf_dout),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .row_pair_cnt        (row_pair_cnt),
    .err_len             (err_len),
    .err_lane            (err_lane)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane FIFO model: first-word-fall-through, popped on the DUT's rd_en.
  always_comb begin
    dis_buf_empty = '0;
    dis_buf_dout  = '0;
    for (int i = 0; i < BS; i++) begin
      dis_buf_empty[i]          = (wp[i] == rp[i]);
      dis_buf_dout[i*17 +: 17]  = lmem[i][rp[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < BS; i++)
      if (dis_buf_rd_en[i] && wp[i] != rp[i]) rp[i] <= rp[i] + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_cache_axis_tvalid && m_cache_axis_tready) begin
        if (cache_q.size() == 0) chk("cache_extra", 1, 0);
        else chk("cache_beat", {m_cache_axis_tlast, m_cache_axis_tdata}, cache_q.pop_front());
      end
      if (phase_buf_wr_en) begin
        if (phase_q.size() == 0) chk("phase_extra", 1, 0);
        else chk("phase_word", phase_buf_din, phase_q.pop_front());
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (out_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_word", {m_axis_tlast, m_axis_tdata}, out_q.pop_front());
      end
      if (|dis_buf_rd_en) chk("rd_underflow", dis_buf_rd_en & dis_buf_empty, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [BS*DW-1:0] mk(input int tag, input int b);
    logic [BS*DW-1:0] d;
    for (int i = 0; i < BS; i++) d[i*DW +: DW] = 16'(tag*4096 + b*8 + i);
    return d;
  endfunction

  function automatic logic [BS*PWD-1:0] mkp(input int tag, input int b, input int len);
    logic [BS*PWD-1:0] w;
    for (int i = 0; i < BS; i++)
      w[i*PWD +: PWD] = {(b == len-1), 16'(b*8 + i), 16'(tag*4096 + b*8 + i)};
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [BS*DW-1:0] d, input logic l, output int waits);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!s_axis_tready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) chk("accept_timeout", waits, 0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_row(input bit to_cache, input int tag, input int len, input int nbeats,
                          input int tlast_at, input int stall_at);
    for (int b = 0; b < nbeats; b++) begin
      int w;
      if (to_cache) cache_q.push_back({(b == len-1), mk(tag, b)});
      else          phase_q.push_back(mkp(tag, b, len));
      if (b == stall_at) begin
        s_axis_tdata    = mk(tag, b);
        s_axis_tlast    = (b == tlast_at);
        s_axis_tvalid   = 1'b1;
        phase_buf_pfull = 8'h20;
        repeat (20) begin
          @(negedge clk);
          chk("stall_tready", s_axis_tready, 0);
          chk("stall_wr_en", phase_buf_wr_en, 0);
          tick();
        end
        phase_buf_pfull = '0;
      end
      send_beat(mk(tag, b), (b == tlast_at), w);
      if (b == stall_at) chk("stall_release_wait", w, 0);
    end
  endtask

  task automatic load_word(input logic [BS-1:0] mask, input logic [BS*DW-1:0] d,
                           input logic [BS-1:0] lasts);
    for (int i = 0; i < BS; i++)
      if (mask[i]) begin
        lmem[i][wp[i] % 64] = {lasts[i], d[i*DW +: DW]};
        wp[i]++;
      end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_cache_tvalid", m_cache_axis_tvalid, 0);
    chk("rst_wr_en", phase_buf_wr_en, 0);
    chk("rst_rd_en", dis_buf_rd_en, 0);
    chk("rst_pair_cnt", row_pair_cnt, 0);
    chk("rst_errs", {err_len, err_lane}, 0);

    // 1: swap=0, 160-beat rows, cache backpressure first
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("cache_bp_tready", s_axis_tready, 0);
    m_cache_axis_tready = 1'b1;
    tick();
    send_row(1, 1, 160, 160, 159, -1);
    send_row(0, 2, 160, 160, 159, -1);
    chk("t1_pair_cnt", row_pair_cnt, 1);
    chk("t1_err_len", err_len, 0);
    chk("t1_cache_left", cache_q.size(), 0);

    // 2: swap=1, two back-to-back pairs with one idle bubble between them
    cfg_swap = 1'b1;
    cfg_row_beats = 11'd4;
    tick();
    send_row(0, 3, 4, 4, 3, -1);
    send_row(1, 4, 4, 4, 3, -1);
    @(negedge clk);
    chk("bubble_idle", s_axis_tready, 0);
    @(negedge clk);
    chk("bubble_resume", s_axis_tready, 1);
    tick();
    send_row(0, 5, 4, 4, 3, -1);
    send_row(1, 6, 4, 4, 3, -1);
    chk("t2_pair_cnt", row_pair_cnt, 3);
    chk("t2_err_len", err_len, 0);
    cfg_swap = 1'b0;
    cfg_row_beats = 11'd160;

    // 3: early tlast on the cache row
    send_row(1, 7, 160, 160, 100, -1);
    send_row(0, 8, 160, 160, 159, -1);
    chk("t3_err_len", err_len, 1);
    chk("t3_pair_cnt", row_pair_cnt, 4);
    cfg_row_beats = 11'd64;

    // 4: pfull stall on lane 5 mid phase row
    send_row(1, 9, 64, 64, 63, -1);
    send_row(0, 10, 64, 64, 63, 30);
    chk("t4_pair_cnt", row_pair_cnt, 5);
    chk("t4_err_len_sticky", err_len, 1);
    chk("t4_phase_left", phase_q.size(), 0);

    // 5: lane-aligned reads
    load_word(8'hFB, mk(15, 0), 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("hold_rd_en", dis_buf_rd_en, 0);
      chk("hold_tvalid", m_axis_tvalid, 0);
    end
    tick();
    load_word(8'h04, mk(15, 0), 8'h00);
    out_q.push_back({1'b0, mk(15, 0)});
    @(negedge clk);
    chk("fill_rd_en", dis_buf_rd_en, 8'hFF);
    chk("fill_tvalid_early", m_axis_tvalid, 0);
    @(negedge clk);
    chk("fill_tvalid", m_axis_tvalid, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      load_word(8'hFF, mk(15, k), (k == 8) ? 8'hFF : 8'h00);
      out_q.push_back({(k == 8), mk(15, k)});
    end
    for (int c = 0; c < 60 && out_q.size() != 0; c++) begin
      m_axis_tready = (c % 2 == 0);
      tick();
    end
    m_axis_tready = 1'b1;
    chk("toggle_drain_left", out_q.size(), 0);
    chk("err_lane_clean", err_lane, 0);
    load_word(8'hFF, mk(15, 9), 8'h10);
    out_q.push_back({1'b0, mk(15, 9)});
    repeat (3) tick();
    chk("err_lane_set", err_lane, 1);
    chk("lane_mis_drain_left", out_q.size(), 0);

    // 6: reset mid phase row with a full skid and a word waiting in the lanes
    m_axis_tready = 1'b0;
    for (int k = 10; k <= 12; k++) begin
      load_word(8'hFF, mk(15, k), 8'h00);
      out_q.push_back({1'b0, mk(15, k)});
    end
    send_row(1, 11, 64, 64, 63, -1);
    send_row(0, 12, 64, 40, 63, -1);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    chk("pre_rst_rd_en", dis_buf_rd_en, 0);
    s_axis_tdata  = mk(12, 40);
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_s_tready", s_axis_tready, 0);
    chk("mid_rst_wr_en", phase_buf_wr_en, 0);
    chk("mid_rst_cache_tvalid", m_cache_axis_tvalid, 0);
    chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_rd_en", dis_buf_rd_en, 0);
    chk("mid_rst_pair_cnt", row_pair_cnt, 0);
    chk("mid_rst_errs", {err_len, err_lane}, 0);
    repeat (2) tick();
    s_axis_tvalid = 1'b0;
    out_q.delete();
    out_q.push_back({1'b0, mk(15, 12)});
    cfg_swap = 1'b1;
    cfg_row_beats = 11'd8;
    rst = 1'b0;
    m_axis_tready = 1'b1;
    send_row(0, 13, 8, 8, 7, -1);
    send_row(1, 14, 8, 8, 7, -1);
    repeat (3) tick();
    chk("t6_pair_cnt", row_pair_cnt, 1);
    chk("t6_err_len", err_len, 0);
    chk("t6_cache_left", cache_q.size(), 0);
    chk("t6_phase_left", phase_q.size(), 0);
    chk("t6_out_left", out_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
